updown_sweep_ctrl: RTL and testbench
====================================

# updown_sweep_ctrl

Sequencer that drives an up/down counting datapath through programmed triangular sweeps. On `start` it latches a sweep configuration (lower bound, upper bound, dwell, repetitions). It then counts up to the upper bound, holds, counts down to the lower bound, holds, and repeats. It sits between a configuration/command source and any consumer of a ramping count, such as a DAC ramp or a PWM duty stepper, and replaces free-running direction toggling with a bounded, repeatable, abortable sequence.

## Interface
Parameters:
- `WIDTH`, 4: count, `lo` and `hi` width
- `DWELL_W`, 4: dwell field width
- `REPS_W`, 4: repetition field width

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin sweep; sampled only in IDLE
- `abort`  in  1  terminate sweep; highest priority
- `lo`  in  WIDTH  lower bound, unsigned
- `hi`  in  WIDTH  upper bound, unsigned
- `dwell`  in  DWELL_W  extra hold cycles at each bound
- `reps`  in  REPS_W  number of full up/down sweeps
- `count`  out  WIDTH  registered sweep value
- `up_down`  out  1  direction of the next count move: 1 = up, 0 = down
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse on normal completion
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected

## Operation
- States: IDLE, UP, DWELL_HI, DOWN, DWELL_LO.
- **Reset:** state IDLE, `count`=0, `up_down`=1, `busy`=0, `done`=0, `cfg_err`=0. Internal timer and rep counter are cleared.
- **IDLE + start accepted:** requires `lo` < `hi` and `reps` ≠ 0.
  - Latch `lo`, `hi`, `dwell`, `reps`; load the rep counter with `reps`.
  - `count` ← `lo`; go to UP.
- **IDLE + start rejected:** if `lo` ≥ `hi` or `reps` = 0, pulse `cfg_err`, stay in IDLE, `count` holds.
- **UP:** `count` ← `count`+1 each edge. On the edge where `count` = `hi`−1: `count` ← `hi`, timer ← `dwell`, go to DWELL_HI.
- **DWELL_HI:**
  - timer ≠ 0: decrement timer, `count` holds.
  - timer = 0: `count` ← `hi`−1, go to DOWN.
  - `count` therefore sits at `hi` for `dwell`+1 cycles.
- **DOWN:** `count` ← `count`−1 each edge. On the edge where `count` = `lo`+1: `count` ← `lo`, timer ← `dwell`, go to DWELL_LO.
- **DWELL_LO:**
  - timer ≠ 0: decrement timer.
  - timer = 0 and rep counter = 1: go to IDLE, pulse `done`.
  - timer = 0 and rep counter > 1: decrement rep counter, `count` ← `lo`+1, go to UP.
- **up_down decode:** 1 in IDLE, UP and DWELL_LO; 0 in DWELL_HI and DOWN. Combinational from state.
- **Abort:** in any non-IDLE state, go to IDLE on the next edge. `count` holds its value, no `done`, no `cfg_err`.
- **Abort + start together in IDLE:** abort wins; no start, no `cfg_err`.
- **start while busy:** ignored.
- **Configuration changes during a sweep:** ignored; the latched copy is used.
- **No wrap-around:** `count` always stays within [`lo`, `hi`]. The `lo` < `hi` check guarantees no overflow or underflow.
- **Reset mid-sweep:** immediate return to the reset values, independent of `clk`.

## Timing
- All outputs are registered except `up_down`, which is decoded from state.
- Start latency: `start` sampled at edge E0 → `count` = `lo` and `busy` = 1 after E0.
- Completion: `done` and `busy`=0 appear together after edge E0+N, where N = `reps`·(2·(`hi`−`lo`) + 2·`dwell`) + 1.
- `done` and `cfg_err` are high for exactly one cycle each.
- Abort latency: one edge.
- A new `start` is accepted on the cycle in which `done` is high, since state is already IDLE.

## Structure
- Package `updown_sweep_pkg`:
  - state enum `sweep_state_t`
  - a `DIR_UP`/`DIR_DOWN` localparam pair
- Sub-module `sweep_step_core`: owns the `count` register, with controls load (value), inc and dec. Loading has priority over inc/dec.
- The FSM, dwell timer and rep counter live in the top module.

## Test plan
- Single sweep: `lo`=2, `hi`=5, `dwell`=1, `reps`=1. Expect `count` = 2,3,4,5,5,4,3,2,2 on successive cycles, then `done` one cycle after edge E0+9 and `busy`=0.
- Multi-rep: `lo`=0, `hi`=2, `dwell`=0, `reps`=3. Expect `count` 0,1,2,1,0,1,2,1,0,1,2,1,0 and `done` after E0+13; `up_down` falls exactly on the cycles where `count`=2.
- Config errors: `start` with `lo`=7, `hi`=7 → `cfg_err` pulse, `busy` stays 0; `start` with `reps`=0 → `cfg_err` pulse; `count` unchanged in both cases.
- Abort: abort asserted in DOWN with `count`=4 → IDLE next edge, `count`=4 holds, no `done`; a subsequent valid `start` runs normally.
- Priority and ignore: `start` and `abort` together in IDLE → nothing happens. `start` with new `lo`/`hi` during a sweep → ignored, and the original bounds are kept.
- Async reset: assert `rst` mid-DWELL_HI between clock edges → `count`=0, `busy`=0 and `up_down`=1 immediately. After release, `lo`=0, `hi`=15, `dwell`=0, `reps`=1 reaches 15 with no wrap and finishes after E0+31.

Source files
------------

// File: rtl/updown_sweep_pkg.sv
// Shared types and constants for the triangular up/down sweep sequencer.
package updown_sweep_pkg;

    typedef logic [2:0] sweep_state_t;

    localparam sweep_state_t ST_IDLE     = 3'd0;
    localparam sweep_state_t ST_UP       = 3'd1;
    localparam sweep_state_t ST_DWELL_HI = 3'd2;
    localparam sweep_state_t ST_DOWN     = 3'd3;
    localparam sweep_state_t ST_DWELL_LO = 3'd4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/sweep_step_core.sv
// Count register with load/increment/decrement controls; load wins over inc/dec.
module sweep_step_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end else if (dec) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sequencer driving bounded, repeatable, abortable triangular sweeps between lo and hi
// with a programmable dwell at each bound.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int REPS_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [REPS_W-1:0]  reps,
    output logic [WIDTH-1:0]   count,
    output logic               up_down,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    sweep_state_t        state_q, state_d;
    logic [DWELL_W-1:0]  timer_q, timer_d;
    logic [REPS_W-1:0]   rep_q, rep_d;
    logic [WIDTH-1:0]    lo_q, hi_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic                cfg_ld, done_d, err_d;
    logic                ld, inc, dec;
    logic [WIDTH-1:0]    ld_val;
    logic [WIDTH-1:0]    hi_m1, lo_p1;

    assign hi_m1 = hi_q - WIDTH'(1);
    assign lo_p1 = lo_q + WIDTH'(1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rep_d   = rep_q;
        cfg_ld  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ld      = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        ld_val  = count;
        // Abort in IDLE also suppresses start and the config check.
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if ((lo < hi) && (reps != '0)) begin
                            cfg_ld  = 1'b1;
                            rep_d   = reps;
                            ld      = 1'b1;
                            ld_val  = lo;
                            state_d = ST_UP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_UP: begin
                    if (count == hi_m1) begin
                        ld      = 1'b1;
                        ld_val  = hi_q;
                        timer_d = dwell_q;
                        state_d = ST_DWELL_HI;
                    end else begin
                        inc = 1'b1;
                    end
                end
                ST_DWELL_HI: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - DWELL_W'(1);
                    end else if (hi_m1 == lo_q) begin
                        // Adjacent bounds: no interior ramp points, go straight to the low hold.
                        ld      = 1'b1;
                        ld_val  = lo_q;
                        timer_d = dwell_q;
                        state_d = ST_DWELL_LO;
                    end else begin
                        ld      = 1'b1;
                        ld_val  = hi_m1;
                        state_d = ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (count == lo_p1) begin
                        ld      = 1'b1;
                        ld_val  = lo_q;
                        timer_d = dwell_q;
                        state_d = ST_DWELL_LO;
                    end else begin
                        dec = 1'b1;
                    end
                end
                ST_DWELL_LO: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - DWELL_W'(1);
                    end else if (rep_q == REPS_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rep_d = rep_q - REPS_W'(1);
                        ld    = 1'b1;
                        if (lo_p1 == hi_q) begin
                            ld_val  = hi_q;
                            timer_d = dwell_q;
                            state_d = ST_DWELL_HI;
                        end else begin
                            ld_val  = lo_p1;
                            state_d = ST_UP;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            rep_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rep_q   <= rep_d;
            busy    <= (state_d != ST_IDLE);
            done    <= done_d;
            cfg_err <= err_d;
            if (cfg_ld) begin
                lo_q    <= lo;
                hi_q    <= hi;
                dwell_q <= dwell;
            end
        end
    end

    assign up_down = ((state_q == ST_DWELL_HI) || (state_q == ST_DOWN)) ? DIR_DOWN : DIR_UP;

    sweep_step_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .inc      (inc),
        .dec      (dec),
        .count    (count)
    );

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: directed and randomized sweeps against a
// sequence-list reference model.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] dwell;
    logic [3:0] reps;
    logic [3:0] count;
    logic       up_down;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    updown_sweep_ctrl #(
        .WIDTH   (4),
        .DWELL_W (4),
        .REPS_W  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .lo      (lo),
        .hi      (hi),
        .dwell   (dwell),
        .reps    (reps),
        .count   (count),
        .up_down (up_down),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int exp_count, input logic exp_err);
        check({tag, " count"}, 32'(count), exp_count);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " cfg_err"}, 32'(cfg_err), 32'(exp_err));
        check({tag, " up_down"}, 32'(up_down), 1);
    endtask

    // stop_kind: 0 = run to completion, 1 = abort after step stop_at, 2 = async reset there.
    task automatic run_sweep(input int lo_v, input int hi_v, input int dw_v, input int rp_v,
                             input int stop_at, input int stop_kind);
        int ec[$];
        int eu[$];
        int n;
        // The triangle as a plain list of (count, direction) per cycle after the start edge.
        ec.push_back(lo_v);
        eu.push_back(1);
        for (int r = 0; r < rp_v; r++) begin
            for (int v = lo_v + 1; v < hi_v; v++) begin ec.push_back(v); eu.push_back(1); end
            for (int k = 0; k <= dw_v; k++) begin ec.push_back(hi_v); eu.push_back(0); end
            for (int v = hi_v - 1; v > lo_v; v--) begin ec.push_back(v); eu.push_back(0); end
            for (int k = 0; k <= dw_v; k++) begin ec.push_back(lo_v); eu.push_back(1); end
        end
        n = ec.size();
        lo    = 4'(lo_v);
        hi    = 4'(hi_v);
        dwell = 4'(dw_v);
        reps  = 4'(rp_v);
        start = 1'b1;
        abort = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            check("sweep count", 32'(count), ec[i]);
            check("sweep up_down", 32'(up_down), eu[i]);
            check("sweep busy", 32'(busy), 1);
            check("sweep done", 32'(done), 0);
            check("sweep cfg_err", 32'(cfg_err), 0);
            if (i == stop_at && stop_kind == 1) begin
                abort = 1'b1;
                start = 1'(($urandom % 2));
                tick();
                abort = 1'b0;
                start = 1'b0;
                check_idle("abort", ec[i], 1'b0);
                tick();
                check_idle("post-abort", ec[i], 1'b0);
                return;
            end
            if (i == stop_at && stop_kind == 2) begin
                start = 1'b0;
                #2 rst = 1'b1;
                #1;
                check_idle("async reset", 0, 1'b0);
                #1 rst = 1'b0;
                tick();
                check_idle("post-reset", 0, 1'b0);
                return;
            end
            // Config and start changes while busy must be ignored.
            lo    = 4'($urandom);
            hi    = 4'($urandom);
            dwell = 4'($urandom);
            reps  = 4'($urandom);
            start = 1'(($urandom % 2));
            tick();
        end
        start = 1'b0;
        check("done pulse", 32'(done), 1);
        check("done busy", 32'(busy), 0);
        check("done count", 32'(count), lo_v);
        check("done up_down", 32'(up_down), 1);
        check("done cfg_err", 32'(cfg_err), 0);
        tick();
        check_idle("after done", lo_v, 1'b0);
    endtask

    initial begin
        int l;
        int h;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        lo    = '0;
        hi    = '0;
        dwell = '0;
        reps  = '0;
        tick();
        check_idle("reset", 0, 1'b0);
        rst = 1'b0;
        tick();
        check_idle("reset release", 0, 1'b0);

        run_sweep(2, 5, 1, 1, -1, 0);
        run_sweep(0, 2, 0, 3, -1, 0);

        // Rejected configurations.
        lo = 4'd7; hi = 4'd7; dwell = 4'd2; reps = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check_idle("cfg lo==hi", 0, 1'b1);
        tick();
        check_idle("cfg lo==hi clear", 0, 1'b0);
        lo = 4'd1; hi = 4'd9; reps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check_idle("cfg reps==0", 0, 1'b1);
        tick();
        check_idle("cfg reps==0 clear", 0, 1'b0);
        lo = 4'd12; hi = 4'd3; reps = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check_idle("cfg lo>hi", 0, 1'b1);

        // Abort and start together in IDLE, with valid and invalid configs.
        lo = 4'd1; hi = 4'd6; reps = 4'd1; start = 1'b1; abort = 1'b1;
        tick();
        check_idle("start+abort valid", 0, 1'b0);
        lo = 4'd6; hi = 4'd6;
        tick();
        start = 1'b0; abort = 1'b0;
        check_idle("start+abort invalid", 0, 1'b0);

        // Abort in DOWN with count 4, then a normal run.
        run_sweep(1, 6, 0, 1, 7, 1);
        run_sweep(3, 8, 2, 2, -1, 0);

        // Adjacent bounds.
        run_sweep(4, 5, 1, 2, -1, 0);

        // Async reset during DWELL_HI, then a full-range run.
        run_sweep(3, 9, 3, 2, 7, 2);
        run_sweep(0, 15, 0, 1, -1, 0);

        for (int t = 0; t < 8; t++) begin
            l = int'($urandom_range(0, 13));
            h = int'($urandom_range(l + 1, 15));
            run_sweep(l, h, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
